// File: rtl/cache_msg_dispatch.sv
// MESI output-pair dispatcher: FIFO-buffered, serialised into bus/L1 beats.
// Optional per-kind beat counters are enabled with `define MSG_STATS_EN.
package cache_msg_pkg;
    typedef enum logic [2:0] {
        NULL = 3'd0, READ, WRITE, INVALIDATE, RWIM
    } bus_struct;
    typedef enum logic [2:0] {
        NULLMsg = 3'd0, GETLINE, SENDLINE, INVALIDATELINE, EVICTLINE
    } l2tol1_struct;
endpackage

module cache_msg_dispatch
    import cache_msg_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  bus_struct                  in_bus_op,
    input  l2tol1_struct               in_l1_msg,
    input  logic [ADDR_W-1:0]          in_addr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_kind,
    output bus_struct                  out_bus_op,
    output l2tol1_struct               out_l1_msg,
    output logic [ADDR_W-1:0]          out_addr,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_cnt
`ifdef MSG_STATS_EN
    ,
    output logic [CNT_W-1:0]           stat_read,
    output logic [CNT_W-1:0]           stat_write,
    output logic [CNT_W-1:0]           stat_inval,
    output logic [CNT_W-1:0]           stat_rwim,
    output logic [CNT_W-1:0]           stat_sendline,
    output logic [CNT_W-1:0]           stat_evict
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_L1   = 2'd2;

    bus_struct         bus_mem  [DEPTH];
    l2tol1_struct      l1_mem   [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [1:0]        state_q, state_d;
    logic              valid_q, valid_d, kind_q, kind_d;
    bus_struct         bus_q, bus_d;
    l2tol1_struct      l1_q, l1_d, hold_l1_q, hold_l1_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic              push_req, full, push, drop, pop;

    // Full comes from the registered count, so a same-cycle pop never frees room
    always_comb begin
        push_req = in_valid && (in_bus_op != NULL || in_l1_msg != NULLMsg);
        full     = count_q == CW'(DEPTH);
        push     = push_req && !full;
        drop     = push_req && full;
        pop      = (state_q == S_IDLE) && (count_q != '0);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) count_d = count_q + CW'(1);
        if (!push && pop) count_d = count_q - CW'(1);
        ovf_d    = ovf_q | drop;
        drop_d   = (drop && drop_q != '1) ? drop_q + CNT_W'(1) : drop_q;
    end

    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        kind_d    = kind_q;
        bus_d     = bus_q;
        l1_d      = l1_q;
        addr_d    = addr_q;
        hold_l1_d = hold_l1_q;
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    valid_d   = 1'b1;
                    addr_d    = addr_mem[rd_ptr_q];
                    hold_l1_d = l1_mem[rd_ptr_q];
                    if (bus_mem[rd_ptr_q] != NULL) begin
                        state_d = S_BUS;
                        kind_d  = 1'b0;
                        bus_d   = bus_mem[rd_ptr_q];
                        l1_d    = NULLMsg;
                    end else begin
                        state_d = S_L1;
                        kind_d  = 1'b1;
                        bus_d   = NULL;
                        l1_d    = l1_mem[rd_ptr_q];
                    end
                end
            end
            S_BUS: begin
                if (out_ready) begin
                    if (hold_l1_q != NULLMsg) begin
                        state_d = S_L1;
                        kind_d  = 1'b1;
                        bus_d   = NULL;
                        l1_d    = hold_l1_q;
                    end else begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                        kind_d  = 1'b0;
                        bus_d   = NULL;
                        l1_d    = NULLMsg;
                        addr_d  = '0;
                    end
                end
            end
            S_L1: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    kind_d  = 1'b0;
                    bus_d   = NULL;
                    l1_d    = NULLMsg;
                    addr_d  = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            bus_mem[wr_ptr_q]  <= in_bus_op;
            l1_mem[wr_ptr_q]   <= in_l1_msg;
            addr_mem[wr_ptr_q] <= in_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            valid_q   <= 1'b0;
            kind_q    <= 1'b0;
            bus_q     <= NULL;
            l1_q      <= NULLMsg;
            addr_q    <= '0;
            hold_l1_q <= NULLMsg;
            ovf_q     <= 1'b0;
            drop_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            valid_q   <= valid_d;
            kind_q    <= kind_d;
            bus_q     <= bus_d;
            l1_q      <= l1_d;
            addr_q    <= addr_d;
            hold_l1_q <= hold_l1_d;
            ovf_q     <= ovf_d;
            drop_q    <= drop_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_kind   = kind_q;
    assign out_bus_op = bus_q;
    assign out_l1_msg = l1_q;
    assign out_addr   = addr_q;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign drop_cnt   = drop_q;

`ifdef MSG_STATS_EN
    logic [CNT_W-1:0] st_q [6];
    logic [5:0]       hit;
    logic             hs;

    always_comb begin
        hs     = valid_q && out_ready;
        hit[0] = hs && bus_q == READ;
        hit[1] = hs && bus_q == WRITE;
        hit[2] = hs && bus_q == INVALIDATE;
        hit[3] = hs && bus_q == RWIM;
        hit[4] = hs && l1_q == SENDLINE;
        hit[5] = hs && l1_q == EVICTLINE;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 6; i++) begin
            if (rst) st_q[i] <= '0;
            else if (hit[i] && st_q[i] != '1) st_q[i] <= st_q[i] + CNT_W'(1);
        end
    end

    assign stat_read     = st_q[0];
    assign stat_write    = st_q[1];
    assign stat_inval    = st_q[2];
    assign stat_rwim     = st_q[3];
    assign stat_sendline = st_q[4];
    assign stat_evict    = st_q[5];
`endif
endmodule

// File: tb/tb_cache_msg_dispatch.sv
// Scoreboard bench for cache_msg_dispatch: queue-level reference model,
// random traffic with stalls and resets, separate beat monitor.
module tb_cache_msg_dispatch;
    import cache_msg_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    bus_struct         in_bus_op;
    l2tol1_struct      in_l1_msg;
    logic [ADDR_W-1:0] in_addr;
    logic              out_valid;
    logic              out_ready;
    logic              out_kind;
    bus_struct         out_bus_op;
    l2tol1_struct      out_l1_msg;
    logic [ADDR_W-1:0] out_addr;
    logic [3:0]        fifo_count;
    logic              overflow;
    logic [CNT_W-1:0]  drop_cnt;
`ifdef MSG_STATS_EN
    logic [CNT_W-1:0]  stat_read, stat_write, stat_inval;
    logic [CNT_W-1:0]  stat_rwim, stat_sendline, stat_evict;
`endif

    always #5 clk = ~clk;

    cache_msg_dispatch #(
        .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_bus_op(in_bus_op),
        .in_l1_msg(in_l1_msg), .in_addr(in_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_kind(out_kind), .out_bus_op(out_bus_op),
        .out_l1_msg(out_l1_msg), .out_addr(out_addr),
        .fifo_count(fifo_count), .overflow(overflow),
        .drop_cnt(drop_cnt)
`ifdef MSG_STATS_EN
        ,
        .stat_read(stat_read), .stat_write(stat_write),
        .stat_inval(stat_inval), .stat_rwim(stat_rwim),
        .stat_sendline(stat_sendline), .stat_evict(stat_evict)
`endif
    );

    typedef struct {
        bus_struct    b;
        l2tol1_struct m;
        logic [31:0]  a;
    } ent_t;

    typedef struct {
        logic         kind;
        bus_struct    b;
        l2tol1_struct m;
        logic [31:0]  a;
    } beat_t;

    typedef beat_t beat_q_t[$];

    ent_t  m_q[$];
    beat_t m_cur[$];
    beat_t exp_q[$];
    logic  m_ovf;
    int    m_drop;
    int    rst_cnt;
    int    s_cnt[6];
    int    total, bad;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // An entry becomes its bus beat (if any) followed by its L1 beat (if any)
    function automatic beat_q_t beats_of(ent_t e);
        beat_q_t q;
        beat_t   bt;
        if (e.b != NULL) begin
            bt = '{kind: 1'b0, b: e.b, m: NULLMsg, a: e.a};
            q.push_back(bt);
        end
        if (e.m != NULLMsg) begin
            bt = '{kind: 1'b1, b: NULL, m: e.m, a: e.a};
            q.push_back(bt);
        end
        return q;
    endfunction

    task automatic model_update();
        bit      full;
        ent_t    e;
        beat_q_t bq;
        if (rst) begin
            m_q.delete();
            m_cur.delete();
            exp_q.delete();
            m_ovf = 1'b0;
            m_drop = 0;
            rst_cnt++;
            for (int i = 0; i < 6; i++) s_cnt[i] = 0;
            return;
        end
        full = (m_q.size() == DEPTH);
        if (m_cur.size() == 0) begin
            if (m_q.size() != 0) begin
                e = m_q.pop_front();
                m_cur = beats_of(e);
            end
        end else if (out_ready) begin
            void'(m_cur.pop_front());
        end
        if (in_valid && (in_bus_op != NULL || in_l1_msg != NULLMsg)) begin
            if (full) begin
                m_ovf = 1'b1;
                if (m_drop < 65535) m_drop++;
            end else begin
                e = '{b: in_bus_op, m: in_l1_msg, a: in_addr};
                m_q.push_back(e);
                bq = beats_of(e);
                foreach (bq[i]) exp_q.push_back(bq[i]);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
        chk("count", 64'(fifo_count), 64'(m_q.size()));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
        chk("out_valid", 64'(out_valid), 64'(m_cur.size() != 0));
    endtask

    task automatic drive(logic v, bus_struct b, l2tol1_struct m,
                         logic [31:0] a, logic r);
        in_valid  = v;
        in_bus_op = b;
        in_l1_msg = m;
        in_addr   = a;
        out_ready = r;
    endtask

    task automatic monitor();
        logic         hold = 1'b0;
        int           rc = 0;
        logic         sk;
        bus_struct    sb;
        l2tol1_struct sm;
        logic [31:0]  sa;
        beat_t        e;
        forever begin
            @(negedge clk);
            if (hold && rc == rst_cnt) begin
                chk("stable_kind", 64'(out_kind), 64'(sk));
                chk("stable_bus", 64'(out_bus_op), 64'(sb));
                chk("stable_l1", 64'(out_l1_msg), 64'(sm));
                chk("stable_addr", 64'(out_addr), 64'(sa));
            end
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL beat: got unexpected beat addr %0h want none",
                             out_addr);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_kind", 64'(out_kind), 64'(e.kind));
                    chk("beat_bus", 64'(out_bus_op), 64'(e.b));
                    chk("beat_l1", 64'(out_l1_msg), 64'(e.m));
                    chk("beat_addr", 64'(out_addr), 64'(e.a));
                    if (e.b == READ) s_cnt[0]++;
                    if (e.b == WRITE) s_cnt[1]++;
                    if (e.b == INVALIDATE) s_cnt[2]++;
                    if (e.b == RWIM) s_cnt[3]++;
                    if (e.m == SENDLINE) s_cnt[4]++;
                    if (e.m == EVICTLINE) s_cnt[5]++;
                end
            end
            hold = out_valid && !out_ready && !rst;
            sk = out_kind;
            sb = out_bus_op;
            sm = out_l1_msg;
            sa = out_addr;
            rc = rst_cnt;
        end
    endtask

    initial begin
        int  waited;
        bit  slow;
        total = 0;
        bad = 0;
        rst_cnt = 0;
        m_ovf = 1'b0;
        m_drop = 0;
        for (int i = 0; i < 6; i++) s_cnt[i] = 0;
        rst = 1'b1;
        drive(0, NULL, NULLMsg, 0, 0);
        fork
            monitor();
        join_none

        repeat (2) cycle();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_kind", 64'(out_kind), 64'd0);
        chk("rst_bus", 64'(out_bus_op), 64'(NULL));
        chk("rst_l1", 64'(out_l1_msg), 64'(NULLMsg));
        chk("rst_addr", 64'(out_addr), 64'd0);
        chk("rst_count", 64'(fifo_count), 64'd0);
        rst = 1'b0;

        // single pair: READ then SENDLINE
        drive(1, READ, SENDLINE, 32'h1000, 1);
        cycle();
        drive(0, NULL, NULLMsg, 0, 1);
        chk("t1_not_yet", 64'(out_valid), 64'd0);
        cycle();
        chk("t1_latency", 64'(out_valid), 64'd1);
        repeat (4) cycle();
        chk("t1_empty", 64'(fifo_count), 64'd0);

        // all-NULL is ignored, bus-only gives one beat
        drive(1, NULL, NULLMsg, 32'h55, 1);
        cycle();
        chk("t2_null_count", 64'(fifo_count), 64'd0);
        chk("t2_null_drop", 64'(drop_cnt), 64'd0);
        drive(1, WRITE, NULLMsg, 32'h2040, 1);
        cycle();
        drive(0, NULL, NULLMsg, 0, 1);
        repeat (5) cycle();

        // nine pushes against a stalled consumer
        for (int i = 0; i < 9; i++) begin
            drive(1, bus_struct'(1 + i % 4), l2tol1_struct'(i % 5),
                  32'h3000 + 32'(i * 64), 0);
            cycle();
        end
        chk("t3_count", 64'(fifo_count), 64'd8);
        chk("t3_nodrop", 64'(drop_cnt), 64'd0);
        drive(0, NULL, NULLMsg, 0, 1);
        repeat (40) cycle();

        // full FIFO, pop and push in the same cycle drops the push
        drive(1, READ, NULLMsg, 32'h4000, 0);
        cycle();
        for (int i = 0; i < 8; i++) begin
            drive(1, WRITE, EVICTLINE, 32'h4100 + 32'(i * 64), 0);
            cycle();
        end
        chk("t4_full", 64'(fifo_count), 64'd8);
        drive(0, NULL, NULLMsg, 0, 1);
        cycle();
        drive(1, RWIM, GETLINE, 32'h4f00, 0);
        cycle();
        chk("t4_count", 64'(fifo_count), 64'd7);
        chk("t4_overflow", 64'(overflow), 64'd1);
        drive(0, NULL, NULLMsg, 0, 1);
        repeat (40) cycle();

        // long stall, then reset while a beat is pending
        drive(1, RWIM, GETLINE, 32'h5000, 0);
        cycle();
        drive(0, NULL, NULLMsg, 0, 0);
        repeat (7) cycle();
        rst = 1'b1;
        cycle();
        chk("t5_valid", 64'(out_valid), 64'd0);
        chk("t5_count", 64'(fifo_count), 64'd0);
        rst = 1'b0;

`ifdef MSG_STATS_EN
        drive(1, RWIM, SENDLINE, 32'h6000, 1);
        cycle();
        drive(1, WRITE, EVICTLINE, 32'h6040, 1);
        cycle();
        drive(0, NULL, NULLMsg, 0, 1);
        repeat (10) cycle();
        chk("t6_read", 64'(stat_read), 64'd0);
        chk("t6_write", 64'(stat_write), 64'd1);
        chk("t6_inval", 64'(stat_inval), 64'd0);
        chk("t6_rwim", 64'(stat_rwim), 64'd1);
        chk("t6_sendline", 64'(stat_sendline), 64'd1);
        chk("t6_evict", 64'(stat_evict), 64'd1);
`endif

        // random traffic with alternating fast and stalled consumer phases
        slow = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (n % 64 == 0) slow = ~slow;
            rst = ($urandom_range(0, 299) == 0);
            drive($urandom_range(0, 9) < 6,
                  bus_struct'($urandom_range(0, 4)),
                  l2tol1_struct'($urandom_range(0, 4)),
                  $urandom,
                  slow ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 9));
            cycle();
        end

        rst = 1'b0;
        drive(0, NULL, NULLMsg, 0, 1);
        waited = 0;
        while ((exp_q.size() != 0 || out_valid) && waited < 200) begin
            cycle();
            waited++;
        end
        cycle();
        chk("drain_left", 64'(exp_q.size()), 64'd0);

`ifdef MSG_STATS_EN
        chk("st_read", 64'(stat_read), 64'(s_cnt[0]));
        chk("st_write", 64'(stat_write), 64'(s_cnt[1]));
        chk("st_inval", 64'(stat_inval), 64'(s_cnt[2]));
        chk("st_rwim", 64'(stat_rwim), 64'(s_cnt[3]));
        chk("st_sendline", 64'(stat_sendline), 64'(s_cnt[4]));
        chk("st_evict", 64'(stat_evict), 64'(s_cnt[5]));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
